// File: rtl/posit_to_float_pipe_if.sv
// Handshake bundle for the posit -> FP64 converter: posit input stream and
// FP64 result stream. master = producer/consumer side, slave = converter.
interface posit_to_float_pipe_if #(
    parameter int N        = 16,
    parameter int FP_WIDTH = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        operand;
    logic                out_valid;
    logic                out_ready;
    logic [FP_WIDTH-1:0] result;
    logic                nar;

    modport master (
        output in_valid, operand, out_ready,
        input  in_ready, out_valid, result, nar
    );

    modport slave (
        input  in_valid, operand, out_ready,
        output in_ready, out_valid, result, nar
    );
endinterface

// File: rtl/posit_to_float_pipe.sv
// Posit(n, es) -> IEEE-754 binary64 converter, valid/ready handshaked.
// Exact conversion (no rounding). Default build has one register stage (S1).
// Define PDPU_P2F_PIPE2_EN to add a decode register (S0) between the
// sign/abs/regime-count front end and exponent/mantissa assembly.
module posit_to_float_pipe #(
    parameter int n        = 16,
    parameter int es       = 1,
    parameter int FP_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    posit_to_float_pipe_if.slave  bus
);

    // front-end decode results
    logic               f_sign, f_zero, f_nar;
    logic signed [6:0]  f_k;
    logic [n-2:0]       f_rem;
    logic [n-1:0]       abs_v;
    logic [n-2:0]       body;
    logic               r0, run;
    logic [5:0]         m;

    // assembly inputs (either front end directly or the S0 register)
    logic               a_sign, a_zero, a_nar;
    logic signed [6:0]  a_k;
    logic [n-2:0]       a_rem;

    logic [63:0]        w, ws;
    logic [3:0]         e_val;
    logic signed [9:0]  scale;
    logic [10:0]        fp_exp;
    logic [FP_WIDTH-1:0] asm_result;
    logic               asm_nar;

    logic               s1_valid, s1_ready, s1_in_valid;
    logic [FP_WIDTH-1:0] s1_result;
    logic               s1_nar;

    // Sign/abs, regime run length and the bits left after the terminator.
    // Only NaR keeps its MSB set after negation, so it doubles as the NaR flag.
    always_comb begin
        f_sign = bus.operand[n-1];
        abs_v  = f_sign ? -bus.operand : bus.operand;
        body   = abs_v[n-2:0];
        r0     = body[n-2];
        m      = '0;
        run    = 1'b1;
        for (int i = n - 2; i >= 0; i--) begin
            if (run && (body[i] == r0)) m = m + 6'd1;
            else                        run = 1'b0;
        end
        f_k    = r0 ? ($signed({1'b0, m}) - 7'sd1) : -$signed({1'b0, m});
        f_rem  = body << (m + 6'd1);
        f_nar  = abs_v[n-1];
        f_zero = (abs_v == '0);
    end

`ifdef PDPU_P2F_PIPE2_EN
    logic               s0_valid, s0_sign, s0_zero, s0_nar;
    logic signed [6:0]  s0_k;
    logic [n-2:0]       s0_rem;

    assign bus.in_ready = ~s0_valid | s1_ready;
    assign s1_in_valid  = s0_valid;
    assign a_sign = s0_sign;
    assign a_zero = s0_zero;
    assign a_nar  = s0_nar;
    assign a_k    = s0_k;
    assign a_rem  = s0_rem;

    // S0 decode register: loads when empty or draining into S1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_valid <= 1'b0;
            s0_sign  <= 1'b0;
            s0_zero  <= 1'b0;
            s0_nar   <= 1'b0;
            s0_k     <= '0;
            s0_rem   <= '0;
        end else if (bus.in_ready) begin
            s0_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s0_sign <= f_sign;
                s0_zero <= f_zero;
                s0_nar  <= f_nar;
                s0_k    <= f_k;
                s0_rem  <= f_rem;
            end
        end
    end
`else
    assign bus.in_ready = s1_ready;
    assign s1_in_valid  = bus.in_valid;
    assign a_sign = f_sign;
    assign a_zero = f_zero;
    assign a_nar  = f_nar;
    assign a_k    = f_k;
    assign a_rem  = f_rem;
`endif

    // Exponent/mantissa assembly. The remainder is parked at the top of a
    // 64-bit word so missing exponent bits at the LSB end read as zero.
    always_comb begin
        w          = {a_rem, {(65-n){1'b0}}};
        e_val      = w[63:60] >> (4 - es);
        ws         = w << es;
        scale      = (10'(a_k) <<< es) + {6'd0, e_val};
        fp_exp     = 11'(scale) + 11'd1023;
        asm_result = {a_sign, fp_exp, ws[63:12]};
        asm_nar    = 1'b0;
        if (a_nar) begin
            asm_result = 64'h7FF8_0000_0000_0000;
            asm_nar    = 1'b1;
        end else if (a_zero) begin
            asm_result = '0;
        end
    end

    assign s1_ready      = ~s1_valid | bus.out_ready;
    assign bus.out_valid = s1_valid;
    assign bus.result    = s1_result;
    assign bus.nar       = s1_nar;

    // S1 output register: loads when empty or its result leaves this cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_result <= '0;
            s1_nar    <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= s1_in_valid;
            if (s1_in_valid) begin
                s1_result <= asm_result;
                s1_nar    <= asm_nar;
            end
        end
    end

endmodule

// File: tb/tb_posit_to_float_pipe.sv
// Bench for posit_to_float_pipe (n=16, es=1): directed table with latency
// checks, random back-to-back stream with random backpressure against a
// real-arithmetic reference model, and a mid-flight reset sequence.
module tb_posit_to_float_pipe;
    localparam int N  = 16;
    localparam int ES = 1;
`ifdef PDPU_P2F_PIPE2_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    posit_to_float_pipe_if #(.N(N), .FP_WIDTH(64)) bus ();

    posit_to_float_pipe #(.n(N), .es(ES), .FP_WIDTH(64)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [15:0] operand;
        logic [63:0] result;
        logic        nar;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          n_in   = 0;
    int          n_out  = 0;
    logic [64:0] sb[$];
    bit          mon_en = 1'b0;
    bit          stalled = 1'b0;
    logic [64:0] held;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the posit bits and build the value in real arithmetic
    function automatic logic [64:0] ref_model(input logic [15:0] p);
        logic [15:0] a;
        logic        sgn, r0;
        int          i, mm, k, e, sc;
        real         frac, wt, v;
        if (p == 16'h0000) return 65'h0;
        if (p == 16'h8000) return {1'b1, 64'h7FF8_0000_0000_0000};
        sgn = p[15];
        a   = sgn ? (~p + 16'd1) : p;
        r0  = a[14];
        i   = 14;
        mm  = 0;
        while (i >= 0 && a[i] == r0) begin mm++; i--; end
        i--;
        k = r0 ? mm - 1 : -mm;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        frac = 1.0;
        wt   = 0.5;
        while (i >= 0) begin
            if (a[i]) frac = frac + wt;
            wt = wt / 2.0;
            i--;
        end
        sc = k * (1 << ES) + e;
        v  = frac;
        if (sc > 0) repeat (sc) v = v * 2.0;
        else        repeat (-sc) v = v / 2.0;
        if (sgn) v = -v;
        return {1'b0, $realtobits(v)};
    endfunction

    function automatic logic [15:0] gen();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 16'h8000;
        if (r == 1) return 16'h0000;
        return 16'($urandom);
    endfunction

    // Scoreboard monitor: push on input handshake, pop/compare on output
    // handshake, and verify held outputs across stalled cycles.
    always @(negedge clk_i) begin
        if (!rst_ni || !mon_en) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", {bus.out_valid, bus.nar, bus.result}, {1'b1, held});
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_model(bus.operand));
                n_in++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard", bus.result);
                end else begin
                    chk("scoreboard", {1'b0, bus.nar, bus.result}, {1'b0, sb.pop_front()});
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
`ifndef PDPU_P2F_PIPE2_EN
                chk("stall_in_ready", {65'd0, bus.in_ready}, 66'd0);
`endif
                stalled = 1'b1;
                held    = {bus.nar, bus.result};
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        bit   hs;
        int   idx, cyc;

        vt[0] = '{16'h4000, 64'h3FF0_0000_0000_0000, 1'b0};
        vt[1] = '{16'hC000, 64'hBFF0_0000_0000_0000, 1'b0};
        vt[2] = '{16'h5000, 64'h4000_0000_0000_0000, 1'b0};
        vt[3] = '{16'h7FFF, 64'h41B0_0000_0000_0000, 1'b0};
        vt[4] = '{16'h0001, 64'h3E30_0000_0000_0000, 1'b0};
        vt[5] = '{16'h0000, 64'h0000_0000_0000_0000, 1'b0};
        vt[6] = '{16'h8000, 64'h7FF8_0000_0000_0000, 1'b1};

        bus.in_valid  = 1'b0;
        bus.operand   = '0;
        bus.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_out_valid", {65'd0, bus.out_valid}, 66'd0);
        chk("rst_result",    {2'b0, bus.result}, 66'd0);
        chk("rst_nar",       {65'd0, bus.nar}, 66'd0);
        #10 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_in_ready", {65'd0, bus.in_ready}, 66'd1);
        mon_en = 1'b1;

        // directed vectors, one at a time, with latency check
        foreach (vt[t]) begin
            @(posedge clk_i); #1;
            bus.in_valid = 1'b1;
            bus.operand  = vt[t].operand;
            @(negedge clk_i);
            chk("dir_in_ready", {65'd0, bus.in_ready}, 66'd1);
            @(posedge clk_i); #1;
            bus.in_valid = 1'b0;
            repeat (L - 1) @(posedge clk_i);
            @(negedge clk_i);
            chk($sformatf("dir_%h", vt[t].operand),
                {bus.out_valid, bus.nar, bus.result}, {1'b1, vt[t].nar, vt[t].result});
        end
        @(posedge clk_i); #1;

        // back-to-back random stream with random backpressure
        idx = 0;
        cyc = 0;
        bus.in_valid = 1'b1;
        bus.operand  = gen();
        while (idx < 100 && cyc < 5000) begin
            @(negedge clk_i);
            hs = bus.in_ready;
            @(posedge clk_i); #1;
            cyc++;
            if (hs) begin
                idx++;
                bus.operand = gen();
            end
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.in_valid  = 1'b0;
        if (idx < 100) begin
            checks++; errors++;
            $display("FAIL stream_timeout: accepted %0d of 100", idx);
        end
        bus.out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(posedge clk_i);
            cyc++;
        end
        @(negedge clk_i);
        chk("drain_empty", 66'(sb.size()), 66'd0);
        chk("in_out_count", 66'(n_out), 66'(n_in));

        // reset with items in flight
        @(posedge clk_i); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.operand   = 16'h4000;
        @(posedge clk_i); #1;
        bus.operand   = 16'h5000;
        @(posedge clk_i); #1;
        bus.operand   = 16'h3000;
        @(posedge clk_i); #2;
        rst_ni       = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {65'd0, bus.out_valid}, 66'd0);
        sb.delete();
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_in_ready", {65'd0, bus.in_ready}, 66'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            chk("midrst_no_emit", {65'd0, bus.out_valid}, 66'd0);
        end

        // recovery after reset
        @(posedge clk_i); #1;
        bus.in_valid = 1'b1;
        bus.operand  = 16'hC000;
        @(posedge clk_i); #1;
        bus.in_valid = 1'b0;
        repeat (L - 1) @(posedge clk_i);
        @(negedge clk_i);
        chk("post_rst", {bus.out_valid, bus.nar, bus.result},
            {1'b1, 1'b0, 64'hBFF0_0000_0000_0000});
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("post_rst_empty", 66'(sb.size()), 66'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
